// File: rtl/gravity_tick_gen.sv
// Gravity tick generator: emits one-cycle pulses at a level-dependent period,
// with soft-drop speed-up, pause, and period restart.
module gravity_tick_gen #(
  parameter int CNT_W       = 32,
  parameter int BASE_PERIOD = 40000000,
  parameter int STEP        = 2500000,
  parameter int MIN_PERIOD  = 5000000,
  parameter int FAST_PERIOD = 2500000,
  parameter int LVL_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [LVL_W-1:0] level,
  input  logic             fast,
  input  logic             sync_clr,
  output logic             tick,
  output logic [CNT_W-1:0] period_out,
  output logic [15:0]      tick_cnt
);

  // Wide enough that level*STEP and BASE-level*STEP can never wrap.
  localparam int W = ((CNT_W > 32) ? CNT_W : 32) + LVL_W + 1;

  localparam logic [W-1:0] BASE_W = W'(BASE_PERIOD);
  localparam logic [W-1:0] STEP_W = W'(STEP);
  localparam logic [W-1:0] MIN_W  = W'(MIN_PERIOD);
  localparam logic [W-1:0] FAST_W = W'(FAST_PERIOD);
  localparam logic [W-1:0] DIFF_W = W'(BASE_PERIOD - MIN_PERIOD);

  if (MIN_PERIOD < 2) begin : g_chk_min
    $error("gravity_tick_gen: MIN_PERIOD must be >= 2");
  end
  if (FAST_PERIOD < 2) begin : g_chk_fast
    $error("gravity_tick_gen: FAST_PERIOD must be >= 2");
  end
  if (BASE_PERIOD < MIN_PERIOD) begin : g_chk_base_min
    $error("gravity_tick_gen: BASE_PERIOD must be >= MIN_PERIOD");
  end
  if (CNT_W < 62 && longint'(BASE_PERIOD) >= (longint'(1) << CNT_W)) begin : g_chk_base_w
    $error("gravity_tick_gen: BASE_PERIOD must fit in CNT_W bits");
  end

  logic [W-1:0]     prod_w;
  logic [W-1:0]     lp_w;
  logic [W-1:0]     ep_w;
  logic [CNT_W-1:0] ep;

  always_comb begin
    prod_w = W'(level) * STEP_W;
    lp_w   = (prod_w >= DIFF_W) ? MIN_W : (BASE_W - prod_w);
    ep_w   = (fast && (FAST_W < lp_w)) ? FAST_W : lp_w;
  end

  assign ep = CNT_W'(ep_w);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ap_q, ap_d;
  logic             tick_q, tick_d;
  logic [15:0]      tick_cnt_q, tick_cnt_d;
  logic             fast_q, fast_d;
  logic [CNT_W-1:0] ap_cur;

  // fast history is frozen while paused so a press during a pause is
  // still seen as a rising edge when counting resumes.
  always_comb begin
    cnt_d      = cnt_q;
    ap_d       = ap_q;
    tick_d     = 1'b0;
    tick_cnt_d = tick_cnt_q;
    fast_d     = fast_q;
    ap_cur     = ap_q;
    if (sync_clr) begin
      cnt_d  = '0;
      ap_d   = ep;
      fast_d = fast;
    end else if (en) begin
      fast_d = fast;
      if (fast && !fast_q) begin
        ap_cur = ep;
      end
      if (cnt_q >= ap_cur - 1'b1) begin
        cnt_d      = '0;
        tick_d     = 1'b1;
        tick_cnt_d = tick_cnt_q + 16'd1;
        ap_d       = ep;
      end else begin
        cnt_d = cnt_q + 1'b1;
        ap_d  = ap_cur;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      ap_q       <= ep;
      tick_q     <= 1'b0;
      tick_cnt_q <= '0;
      fast_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ap_q       <= ap_d;
      tick_q     <= tick_d;
      tick_cnt_q <= tick_cnt_d;
      fast_q     <= fast_d;
    end
  end

  assign tick       = tick_q;
  assign period_out = ap_q;
  assign tick_cnt   = tick_cnt_q;

endmodule

// File: tb/tb_gravity_tick_gen.sv
// Directed bench for gravity_tick_gen with small periods (20/step 4/min 6/fast 3).
module tb_gravity_tick_gen;

  localparam int CNT_W = 8;
  localparam int LVL_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [LVL_W-1:0] level = '0;
  logic             fast = 1'b0;
  logic             sync_clr = 1'b0;
  logic             tick;
  logic [CNT_W-1:0] period_out;
  logic [15:0]      tick_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gravity_tick_gen #(
    .CNT_W(CNT_W), .BASE_PERIOD(20), .STEP(4), .MIN_PERIOD(6),
    .FAST_PERIOD(3), .LVL_W(LVL_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .level(level), .fast(fast),
    .sync_clr(sync_clr), .tick(tick), .period_out(period_out), .tick_cnt(tick_cnt)
  );

  task automatic check(input string tag, input longint obs, input longint expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts edges until tick is seen high; bounded.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (tick !== 1'b1 && n < 300);
    if (tick !== 1'b1) check("tick_timeout", longint'(tick), 1);
  endtask

  int          n;
  int          bad;
  logic        acc;
  logic [15:0] saved;

  initial begin
    // Reset state
    step(3);
    check("rst_tick", tick, 0);
    check("rst_tick_cnt", tick_cnt, 0);
    check("rst_period", period_out, 20);
    $display("[TB] reset state checked");

    // Level 0 cadence
    rst = 1'b0;
    en  = 1'b1;
    wait_tick(n);
    check("first_tick_delay", n, 20);
    check("tick_cnt_1", tick_cnt, 1);
    check("period_lvl0", period_out, 20);
    step(1);
    check("tick_one_cycle", tick, 0);
    wait_tick(n);
    check("second_period", n + 1, 20);
    wait_tick(n);
    check("third_period", n, 20);
    check("tick_cnt_3", tick_cnt, 3);
    $display("[TB] level0 cadence checked");

    // Level change takes effect at next load point
    step(5);
    level = 3'd2;
    wait_tick(n);
    check("lvl_change_hold", n + 5, 20);
    check("period_lvl2", period_out, 12);
    level = 3'd7;
    wait_tick(n);
    check("lvl2_period", n, 12);
    check("period_lvl7_clamp", period_out, 6);
    wait_tick(n);
    check("lvl7_period", n, 6);
    level = 3'd0;
    wait_tick(n);
    check("lvl7_last", n, 6);
    check("period_back_20", period_out, 20);
    $display("[TB] level transitions checked");

    // Soft drop rising at cnt=10: immediate tick
    step(10);
    fast = 1'b1;
    wait_tick(n);
    check("fast_immediate", n, 1);
    check("period_fast", period_out, 3);
    wait_tick(n);
    check("fast_period", n, 3);
    fast = 1'b0;
    wait_tick(n);
    check("fast_fall_one_more", n, 3);
    check("period_after_fall", period_out, 20);
    wait_tick(n);
    check("slow_after_fall", n, 20);
    $display("[TB] soft drop at cnt=10 checked");

    // Soft drop rising at cnt=1: continue counting to new period
    step(1);
    fast = 1'b1;
    wait_tick(n);
    check("fast_early_rise", n + 1, 3);
    fast = 1'b0;
    wait_tick(n);
    check("fast_early_tail", n, 3);
    wait_tick(n);
    check("fast_early_slow", n, 20);
    $display("[TB] soft drop at cnt=1 checked");

    // Pause for 5 cycles at cnt=8
    step(8);
    saved = tick_cnt;
    en = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      acc = acc | tick;
    end
    check("pause_no_tick", acc, 0);
    check("pause_tick_cnt", tick_cnt, saved);
    check("pause_period", period_out, 20);
    en = 1'b1;
    wait_tick(n);
    check("pause_stretch", n + 13, 25);
    $display("[TB] pause checked");

    // sync_clr at cnt=15
    step(15);
    saved = tick_cnt;
    sync_clr = 1'b1;
    step(1);
    sync_clr = 1'b0;
    check("sclr_tick", tick, 0);
    check("sclr_tick_cnt", tick_cnt, saved);
    wait_tick(n);
    check("sclr_restart", n, 20);
    check("sclr_tick_cnt_inc", tick_cnt, saved + 16'd1);
    $display("[TB] sync_clr checked");

    // rst at cnt=15
    step(15);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("midrst_tick_cnt", tick_cnt, 0);
    check("midrst_tick", tick, 0);
    wait_tick(n);
    check("midrst_first_tick", n, 20);
    check("midrst_tick_cnt_1", tick_cnt, 1);
    $display("[TB] mid-period reset checked");

    // tick_cnt wrap at fastest period
    rst   = 1'b1;
    level = 3'd7;
    fast  = 1'b1;
    step(2);
    rst = 1'b0;
    check("wrap_period", period_out, 3);
    bad = 0;
    for (int i = 0; i < 65535; i++) begin
      wait_tick(n);
      if (n != 3) bad++;
    end
    check("wrap_cadence", bad, 0);
    check("wrap_ffff", tick_cnt, 16'hFFFF);
    wait_tick(n);
    check("wrap_zero", tick_cnt, 0);
    check("wrap_period_at_wrap", n, 3);
    wait_tick(n);
    check("post_wrap_period", n, 3);
    check("post_wrap_cnt", tick_cnt, 1);
    $display("[TB] tick_cnt wrap checked");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
